// File: rtl/fetch_pkg.sv
// Shared types and limits for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned FETCH_MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/grant/rvalid bus between fetch and memory.
interface fetch_if;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata,
        input  instr_err
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata,
        output instr_err
    );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: register-array FIFO with clear; head is read straight
// from storage so there is no push-to-head bypass.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited bus requests,
// discards stale responses after a redirect and buffers words for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_pc_valid,
    input  logic [31:0]   set_pc,
    input  logic          flush_F,
    input  logic          stall_F,
    fetch_if.master       bus,
    output logic          instr_valid_if,
    output logic [31:0]   instr_if,
    output logic          instr_err_if,
    output logic [31:0]   pc_if,
    input  logic          instr_ready_id
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRED_W = 4;

    logic             reset_q;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      head_pc_q, head_pc_d;
    logic [31:0]      pend_addr_q;
    logic             pend_q, pend_d;
    logic             pend_stale_q, pend_stale_d;
    logic [1:0]       outstanding_q, outstanding_d;
    logic [1:0]       discard_q, discard_d;

    logic             redirect;
    logic [31:0]      target;
    logic             credit_ok;
    logic             req_fire;
    logic             stale_fire;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_data;
    fetch_entry_t     head;

    // A request raised but not granted holds its address until gnt, even across redirects.
    assign credit_ok = (outstanding_q < 2'(FETCH_MAX_OUTSTANDING)) &&
                       ((CRED_W'(fifo_count) + CRED_W'(outstanding_q) - CRED_W'(discard_q))
                        < CRED_W'(FIFO_DEPTH));
    assign bus.instr_req  = !reset && (pend_q || (!reset_q && !stall_F && credit_ok));
    assign bus.instr_addr = pend_q ? pend_addr_q : fetch_addr_q;

    always_comb begin
        redirect      = set_pc_valid || flush_F;
        target        = set_pc_valid ? set_pc : head_pc_q;
        req_fire      = bus.instr_req && bus.instr_gnt;
        stale_fire    = req_fire && pend_q && pend_stale_q;
        push          = bus.instr_rvalid && !redirect && (discard_q == '0);
        pop           = instr_valid_if && instr_ready_id && !stall_F && !redirect;
        push_data     = '{rdata: bus.instr_rdata, err: bus.instr_err};
        outstanding_d = outstanding_q + 2'(req_fire) - 2'(bus.instr_rvalid);
        pend_d        = bus.instr_req && !bus.instr_gnt;
        pend_stale_d  = pend_d && (pend_stale_q || redirect);
        discard_d     = discard_q;
        fetch_addr_d  = fetch_addr_q;
        head_pc_d     = head_pc_q;

        if (redirect) begin
            // Everything granted so far, including this cycle's gnt, is now stale.
            discard_d    = outstanding_d;
            fetch_addr_d = target;
            head_pc_d    = target;
        end else begin
            discard_d = discard_q + 2'(stale_fire)
                        - 2'(bus.instr_rvalid && (discard_q != '0));
            if (req_fire && !stale_fire) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            if (pop) begin
                head_pc_d = head_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reset_q       <= 1'b1;
            fetch_addr_q  <= BOOT_ADDR;
            head_pc_q     <= BOOT_ADDR;
            pend_addr_q   <= BOOT_ADDR;
            pend_q        <= 1'b0;
            pend_stale_q  <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            reset_q       <= 1'b0;
            fetch_addr_q  <= fetch_addr_d;
            head_pc_q     <= head_pc_d;
            pend_addr_q   <= bus.instr_addr;
            pend_q        <= pend_d;
            pend_stale_q  <= pend_stale_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .head_valid (instr_valid_if),
        .count      (fifo_count)
    );

    assign instr_if     = head.rdata;
    assign instr_err_if = head.err;
    assign pc_if        = head_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory with random grant/latency, and a
// program-order model of the instruction stream decode should see.
module tb_fetch_unit;

    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, set_pc_valid, flush_F, stall_F, instr_ready_id;
    logic [31:0] set_pc;
    logic        instr_valid_if, instr_err_if;
    logic [31:0] instr_if, pc_if;

    fetch_if bus ();

    fetch_unit #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .set_pc_valid   (set_pc_valid),
        .set_pc         (set_pc),
        .flush_F        (flush_F),
        .stall_F        (stall_F),
        .bus            (bus),
        .instr_valid_if (instr_valid_if),
        .instr_if       (instr_if),
        .instr_err_if   (instr_err_if),
        .pc_if          (pc_if),
        .instr_ready_id (instr_ready_id)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          pops    = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          gnt_block = 0;
    bit          prev_pend = 0;
    bit          saw_err8  = 0;
    logic [31:0] prev_addr;
    logic        cur_req;
    logic [31:0] cur_addr;
    logic [31:0] exp_pc = BOOT;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[8:0] == 9'h008;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive controls, play memory, check any delivered instruction.
    task automatic step(input logic rst, input logic spv, input logic [31:0] spc,
                        input logic fl, input logic st, input logic rdy);
        logic gnt, redir, pop;
        int   qsz;
        @(negedge clk);
        reset = rst; set_pc_valid = spv; set_pc = spc; flush_F = fl;
        stall_F = st; instr_ready_id = rdy;
        bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b0;
        bus.instr_rdata = '0; bus.instr_err = 1'b0;
        #1;
        cur_req  = bus.instr_req;
        cur_addr = bus.instr_addr;
        gnt      = 1'b0;
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (prev_pend) begin
                check("req_hold", 32'(cur_req), 32'd1);
                check("addr_hold", cur_addr, prev_addr);
            end
            qsz = q_addr.size();
            if (qsz > 0 && q_due[0] <= cyc) begin
                bus.instr_rvalid = 1'b1;
                bus.instr_rdata  = mem_word(q_addr[0]);
                bus.instr_err    = mem_err(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            gnt = cur_req && !gnt_block && (int'($urandom_range(99)) < gnt_pct);
            bus.instr_gnt = gnt;
            if (gnt) begin
                check("max_outstanding", 32'(qsz < 2), 32'd1);
                q_addr.push_back(cur_addr);
                q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            end
        end
        #1;
        redir = spv || fl;
        pop   = !rst && instr_valid_if && rdy && !st && !redir;
        if (pop) begin
            check("pop_pc", pc_if, exp_pc);
            check("pop_instr", instr_if, mem_word(exp_pc));
            check("pop_err", 32'(instr_err_if), 32'(mem_err(exp_pc)));
            if (exp_pc == 32'h8 && instr_err_if) saw_err8 = 1;
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (rst) exp_pc = BOOT;
        else if (spv) exp_pc = spc;
        prev_pend = !rst && cur_req && !gnt;
        prev_addr = cur_addr;
        cyc = rst ? 0 : cyc + 1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        bit          found;
        int          pops_before;
        logic [31:0] old_a;
        logic [31:0] spc;
        reset = 1'b1; set_pc_valid = 1'b0; set_pc = '0; flush_F = 1'b0;
        stall_F = 1'b0; instr_ready_id = 1'b0;
        bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b0;
        bus.instr_rdata = '0; bus.instr_err = 1'b0;

        // Reset values
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_req", 32'(cur_req), 32'd0);
        check("rst_addr", cur_addr, BOOT);
        check("rst_valid", 32'(instr_valid_if), 32'd0);
        check("rst_instr", instr_if, 32'd0);
        check("rst_err", 32'(instr_err_if), 32'd0);
        check("rst_pc", pc_if, BOOT);

        // Reset release with a 1-cycle memory
        run(1, 1'b1);
        check("c0_req_masked", 32'(cur_req), 32'd0);
        run(1, 1'b1);
        check("c1_req", 32'(cur_req), 32'd1);
        check("c1_addr", cur_addr, 32'h0);
        run(1, 1'b1);
        check("c2_req", 32'(cur_req), 32'd1);
        check("c2_addr", cur_addr, 32'h4);
        run(1, 1'b1);
        check("c3_valid", 32'(instr_valid_if), 32'd1);
        check("c3_pc", pc_if, 32'h0);
        run(8, 1'b1);

        // Decode back-pressure: credits run out, nothing lost on release
        run(10, 1'b0);
        check("bp_req_low", 32'(cur_req), 32'd0);
        check("bp_valid", 32'(instr_valid_if), 32'd1);
        check("bp_pc", pc_if, exp_pc);
        run(10, 1'b1);

        // Redirect with two requests in flight
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            run(1, 1'b1);
            found = (q_addr.size() == 2);
        end
        check("two_outstanding", 32'(found), 32'd1);
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        run(1, 1'b1);
        check("redir_valid_cleared", 32'(instr_valid_if), 32'd0);
        check("redir_pc", pc_if, 32'h100);
        pops_before = pops;
        run(15, 1'b1);
        check("redir_delivers", 32'(pops > pops_before), 32'd1);

        // flush_F alone with a full FIFO headed by 0x40
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        run(8, 1'b0);
        check("full_valid", 32'(instr_valid_if), 32'd1);
        check("full_pc", pc_if, 32'h40);
        check("full_req_low", 32'(cur_req), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0);
        check("flush_valid", 32'(instr_valid_if), 32'd0);
        check("flush_pc", pc_if, 32'h40);
        check("flush_req", 32'(cur_req), 32'd1);
        check("flush_addr", cur_addr, 32'h40);
        run(2, 1'b0);
        check("flush_r3_valid", 32'(instr_valid_if), 32'd1);
        check("flush_r3_instr", instr_if, mem_word(32'h40));
        run(8, 1'b1);

        // Redirect while a request waits three cycles for gnt
        gnt_block = 1; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            run(1, 1'b1);
            found = cur_req;
        end
        check("pend_seen", 32'(found), 32'd1);
        old_a = cur_addr;
        step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        check("pend_redir_req", 32'(cur_req), 32'd1);
        check("pend_redir_addr", cur_addr, old_a);
        gnt_block = 0;
        run(1, 1'b1);
        check("stale_gnt_addr", cur_addr, old_a);
        run(1, 1'b1);
        check("post_stale_req", 32'(cur_req), 32'd1);
        check("post_stale_addr", cur_addr, 32'h200);
        run(10, 1'b1);

        // Error word at 0x8 delivered, fetch continues at 0xC
        saw_err8 = 0;
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        run(14, 1'b1);
        check("err8_delivered", 32'(saw_err8), 32'd1);
        check("after_err8", 32'(exp_pc > 32'hC), 32'd1);

        // Randomised traffic, stalls and redirects
        pops_before = pops;
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) begin
                gnt_pct = (i % 500 == 0) ? 100 : int'($urandom_range(90, 30));
                lat_max = int'($urandom_range(4, 1));
            end
            spc = {20'h0, 10'($urandom), 2'b00};
            if (i == 1000) spc = 32'hFFFF_FFF8;
            step(1'b0, (i == 1000) || ($urandom_range(39) == 0), spc,
                 $urandom_range(39) == 0, $urandom_range(9) == 0,
                 $urandom_range(3) != 0);
        end
        check("random_progress", 32'(pops - pops_before > 100), 32'd1);

        // Reset mid-stream
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rerst_req", 32'(cur_req), 32'd0);
        check("rerst_valid", 32'(instr_valid_if), 32'd0);
        check("rerst_pc", pc_if, BOOT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
